// File: rtl/enduro_fifo_reset_ctrl_if.sv
// Handshake bundle between the enduro FIFO reset sequencer and its surroundings.
// The slave modport is the sequencer's view; master is the requester/peer side.
interface enduro_fifo_reset_ctrl_if;
    logic flush_req;
    logic peer_ack;
    logic rst_req;
    logic local_rst;
    logic ready;
    logic busy;
    logic done;
    logic timeout_err;

    modport master (
        output flush_req,
        output peer_ack,
        input  rst_req,
        input  local_rst,
        input  ready,
        input  busy,
        input  done,
        input  timeout_err
    );

    modport slave (
        input  flush_req,
        input  peer_ack,
        output rst_req,
        output local_rst,
        output ready,
        output busy,
        output done,
        output timeout_err
    );
endinterface

// File: rtl/enduro_fifo_reset_ctrl.sv
// Reset/flush sequencer for one side of the enduro FIFO: asserts and releases the
// cross-domain reset request, waits for the peer's acknowledge, flags a stuck peer.
module enduro_fifo_reset_ctrl #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    enduro_fifo_reset_ctrl_if.slave     ctrl
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_ACK,
        ST_RELEASE,
        ST_WAIT_REL,
        ST_READY,
        ST_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_req_q, rst_req_d;
    logic             local_rst_q, local_rst_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_err_q, timeout_err_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ASSERT: begin
                if (cnt_q == HOLD_LAST) state_d = ST_WAIT_ACK;
            end
            // ack is checked first so a late ack on the last allowed cycle still wins
            ST_WAIT_ACK: begin
                if (ctrl.peer_ack)        state_d = ST_RELEASE;
                else if (cnt_q == TO_LAST) state_d = ST_ERROR;
            end
            ST_RELEASE: state_d = ST_WAIT_REL;
            ST_WAIT_REL: begin
                if (!ctrl.peer_ack)       state_d = ST_READY;
                else if (cnt_q == TO_LAST) state_d = ST_ERROR;
            end
            ST_READY: begin
                if (ctrl.flush_req) state_d = ST_ASSERT;
            end
            ST_ERROR: begin
                if (ctrl.flush_req) state_d = ST_ASSERT;
            end
            default: state_d = ST_ASSERT;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        rst_req_d     = (state_d == ST_ASSERT) || (state_d == ST_WAIT_ACK);
        local_rst_d   = (state_d != ST_READY);
        ready_d       = (state_d == ST_READY);
        busy_d        = (state_d == ST_ASSERT) || (state_d == ST_WAIT_ACK) ||
                        (state_d == ST_RELEASE) || (state_d == ST_WAIT_REL);
        done_d        = (state_d == ST_READY) && (state_q != ST_READY);
        timeout_err_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            rst_req_q     <= 1'b1;
            local_rst_q   <= 1'b1;
            ready_q       <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rst_req_q     <= rst_req_d;
            local_rst_q   <= local_rst_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ctrl.rst_req     = rst_req_q;
    assign ctrl.local_rst   = local_rst_q;
    assign ctrl.ready       = ready_q;
    assign ctrl.busy        = busy_q;
    assign ctrl.done        = done_q;
    assign ctrl.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_enduro_fifo_reset_ctrl.sv
// Directed bench for the enduro FIFO reset sequencer (HOLD=4, TIMEOUT=16).
// Output vector order: {rst_req, local_rst, ready, busy, done, timeout_err}.
module tb_enduro_fifo_reset_ctrl;

    localparam logic [5:0] V_ASSERT = 6'b110100;   // ASSERT / WAIT_ACK / reset
    localparam logic [5:0] V_REL    = 6'b010100;   // RELEASE / WAIT_REL
    localparam logic [5:0] V_RDY_DN = 6'b001010;   // READY entry cycle
    localparam logic [5:0] V_RDY    = 6'b001000;   // READY steady
    localparam logic [5:0] V_ERR    = 6'b010001;   // ERROR

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    enduro_fifo_reset_ctrl_if bus ();

    enduro_fifo_reset_ctrl #(
        .HOLD_CYCLES   (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctrl(bus)
    );

    always #5 clk = ~clk;

    logic [5:0] obs;
    assign obs = {bus.rst_req, bus.local_rst, bus.ready, bus.busy, bus.done, bus.timeout_err};

    task automatic step(input logic ack, input logic flush);
        bus.peer_ack  = ack;
        bus.flush_req = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int k, input logic [5:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %b want %b", name, k, obs, exp);
        end
    endtask

    // Peer answers 3 cycles into each wait state; edge 0 is reset release or the flush edge.
    task automatic run_handshake(input string tag);
        logic [5:0] exp;
        for (int k = 1; k <= 12; k++) begin
            step((k >= 7) && (k <= 10), 1'b0);
            if (k <= 6)       exp = V_ASSERT;
            else if (k <= 10) exp = V_REL;
            else if (k == 11) exp = V_RDY_DN;
            else              exp = V_RDY;
            check(tag, k, exp);
        end
    endtask

    task automatic do_flush(input string tag);
        step(1'b0, 1'b1);
        check(tag, 0, V_ASSERT);
        bus.flush_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.peer_ack  = 1'b0;
        bus.flush_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, V_ASSERT);
        rst = 1'b0;
        check("post_release", 0, V_ASSERT);
        run_handshake("startup");
    endtask

    task automatic test_flush();
        do_flush("flush_entry");
        run_handshake("flush_seq");
    endtask

    task automatic test_ack_timeout();
        do_flush("ackto_flush");
        for (int k = 1; k <= 21; k++) begin
            step(1'b0, 1'b0);
            if (k == 19) check("ackto_before", k, V_ASSERT);
            if (k == 20) check("ackto_error", k, V_ERR);
            if (k == 21) check("ackto_sticky", k, V_ERR);
        end
        do_flush("ackto_clear");
        run_handshake("ackto_recover");
    endtask

    task automatic test_rel_stuck();
        do_flush("relst_flush");
        for (int k = 1; k <= 24; k++) begin
            step(k >= 7, 1'b0);
            if (k == 8)  check("relst_waitrel", k, V_REL);
            if (k == 23) check("relst_before", k, V_REL);
            if (k == 24) check("relst_error", k, V_ERR);
        end
        do_flush("relst_clear");
        run_handshake("relst_recover");
    endtask

    task automatic test_ack_at_limit();
        do_flush("late_flush");
        for (int k = 1; k <= 23; k++) begin
            step((k == 20) || (k == 21), 1'b0);
            if (k == 19) check("late_waiting", k, V_ASSERT);
            if (k == 20) check("late_release", k, V_REL);
            if (k == 21) check("late_waitrel", k, V_REL);
            if (k == 22) check("late_ready", k, V_RDY_DN);
            if (k == 23) check("late_ready2", k, V_RDY);
        end
    endtask

    task automatic test_async_reset();
        do_flush("async_flush");
        for (int k = 1; k <= 8; k++) begin
            step((k >= 7) && (k <= 10), 1'b0);
        end
        check("async_in_waitrel", 8, V_REL);
        #2;
        rst = 1'b1;
        #1;
        check("async_immediate", 8, V_ASSERT);
        bus.peer_ack = 1'b0;
        @(posedge clk);
        #1;
        check("async_held", 9, V_ASSERT);
        rst = 1'b0;
        run_handshake("async_restart");
    endtask

    initial begin
        test_reset();
        test_flush();
        test_ack_timeout();
        test_rel_stuck();
        test_ack_at_limit();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
